window_gen: RTL and testbench

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/window_gen.sv | 140 ++++++++++++++
 tb/tb_window_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_gen.sv
// window_gen: 3x3 sliding-window generator for a row-major 8-bit pixel stream.
//
// Two line buffers hold the previous two rows. Every accepted pixel shifts
// the 3x3 window register left by one column. The new right-hand column is
// built from the two buffered pixels above it plus the incoming pixel.
// A window is presented only when all nine taps lie inside the frame
// (row >= 2, col >= 2). There is no edge padding.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   pix_in      unsigned 8-bit pixel, row-major order
//   pix_valid   pix_in carries a pixel
//   pix_ready   block can accept a pixel this cycle (= !win_valid || win_ready)
//   window      3x3 window, row-major; [8] is top-left, [0] is bottom-right
//   win_valid   window holds a valid window
//   win_ready   downstream takes the window this cycle
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//   win_count   number of windows handed off (0 unless the counter is built)
//
// Build option: define WINDOW_GEN_COUNT_EN to include the 16-bit hand-off
// counter behind win_count. Without it, win_count is tied to zero.

module window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [8:0][7:0] window,
  output logic            win_valid,
  input  logic            win_ready,
  output logic            frame_done,
  output logic [15:0]     win_count
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [7:0]      lb0_q [IMG_W];
  logic [7:0]      lb1_q [IMG_W];
  logic [8:0][7:0] win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  logic accept;
  logic col_last;
  logic row_last;
  logic win_hit;

  assign pix_ready  = !win_valid_q || win_ready;
  assign window     = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

  assign accept   = pix_valid && pix_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign win_hit  = (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;

    // A hand-off drops valid. An accept that produces a window in the same
    // cycle re-asserts it below, so back-to-back windows carry no bubble.
    if (win_ready) begin
      win_valid_d = 1'b0;
    end

    if (accept) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
      end
      // Shift left one column; the new right column is (lb1, lb0, pixel).
      // The buffers are read before this cycle's write-back.
      win_d = {win_q[7], win_q[6], lb1_q[col_q],
               win_q[4], win_q[3], lb0_q[col_q],
               win_q[1], win_q[0], pix_in};
      if (win_hit) begin
        win_valid_d = 1'b1;
      end
      frame_done_d = col_last && row_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_in;
    end
  end

`ifdef WINDOW_GEN_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (win_valid_q && win_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign win_count = cnt_q;
`else
  assign win_count = '0;
`endif

endmodule

// File: tb/tb_window_gen.sv
module tb_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic            clk;
  logic            reset;
  logic [7:0]      pix_in;
  logic            pix_valid;
  logic            pix_ready;
  logic [8:0][7:0] window;
  logic            win_valid;
  logic            win_ready;
  logic            frame_done;
  logic [15:0]     win_count;

  window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .window     (window),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .frame_done (frame_done),
    .win_count  (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the frame image is tracked by (row, col) position.
  // Each interior pixel position yields the 3x3 neighbourhood ending there.
  logic [7:0]  img [H][W];
  int          m_idx;
  logic [71:0] exp_q [$];
  logic [71:0] got_q [$];
  logic [15:0] m_cnt;
  int          fd_seen;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] addw(input logic [71:0] w, input logic [7:0] b);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = w[k*8 +: 8] + b;
    return r;
  endfunction

  task automatic model_accept(input logic [7:0] p, output bit last);
    int r, c;
    r = m_idx / W;
    c = m_idx % W;
    img[r][c] = p;
    last = 1'b0;
    if (r >= 2 && c >= 2)
      exp_q.push_back({img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                       img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                       img[r][c-2],   img[r][c-1],   img[r][c]});
    m_idx++;
    if (m_idx == W * H) begin
      m_idx = 0;
      last  = 1'b1;
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef WINDOW_GEN_COUNT_EN
    return m_cnt;
`else
    return 16'd0;
`endif
  endfunction

  // One clock cycle. Called at a falling edge; inputs are driven, outputs
  // are checked, and the call returns at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] p, input logic rdy, output bit acc);
    bit          fd_next, stalled;
    logic [71:0] snap;
    pix_valid = v;
    pix_in    = p;
    win_ready = rdy;
    #1;
    chk("pix_ready", 72'(pix_ready), 72'(!win_valid || rdy));
    chk("win_valid", 72'(win_valid), 72'(exp_q.size() != 0));
    chk("win_count", 72'(win_count), 72'(exp_count()));
    stalled = win_valid && !rdy;
    snap    = window;
    if (win_valid && rdy) begin
      if (exp_q.size() != 0) begin
        chk("window", window, exp_q[0]);
        void'(exp_q.pop_front());
      end
      got_q.push_back(window);
      m_cnt++;
    end
    acc     = v && pix_ready;
    fd_next = 1'b0;
    if (acc) model_accept(p, fd_next);
    @(posedge clk);
    @(negedge clk);
    chk("frame_done", 72'(frame_done), 72'(fd_next));
    if (frame_done) fd_seen++;
    if (stalled) chk("hold_window", window, snap);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    #1;
    chk("rst_win_valid", 72'(win_valid), 72'(0));
    chk("rst_frame_done", 72'(frame_done), 72'(0));
    chk("rst_window", window, 72'(0));
    chk("rst_win_count", 72'(win_count), 72'(0));
    chk("rst_pix_ready", 72'(pix_ready), 72'(1));
    exp_q.delete();
    m_idx = 0;
    m_cnt = '0;
    @(negedge clk);
    chk("rst_hold_valid", 72'(win_valid), 72'(0));
    reset = 1'b1;
  endtask

  task automatic drain();
    bit acc;
    int g = 0;
    while ((exp_q.size() != 0 || win_valid) && g < 20) begin
      cycle(1'b0, 8'd0, 1'b1, acc);
      g++;
    end
    chk("drain_empty", 72'(exp_q.size()), 72'(0));
  endtask

  task automatic run_frame(input logic [7:0] base, input int stall, input bit toggle,
                           input logic [71:0] first);
    bit   acc, phase, v, rdy;
    int   i = 0, st = stall, guard = 0;
    phase = 1'b0;
    while (i < W * H && guard < 400) begin
      v     = toggle ? phase : 1'b1;
      phase = !phase;
      rdy   = 1'b1;
      if (st > 0 && win_valid) begin
        rdy = 1'b0;
        st--;
        chk("stall_window", window, first);
      end
      cycle(v, base + 8'(i + 1), rdy, acc);
      if (acc) i++;
      guard++;
    end
    chk("frame_pixels", 72'(i), 72'(W * H));
  endtask

  task automatic partial(input int n);
    bit acc;
    int i = 0, guard = 0;
    while (i < n && guard < 100) begin
      cycle(1'b1, 8'(i + 1), 1'b1, acc);
      if (acc) i++;
      guard++;
    end
  endtask

  typedef struct {
    logic [7:0]  base;
    int          stall;
    bit          toggle;
    logic [71:0] exp_first;
    int          exp_n;
  } vec_t;

  initial begin
    vec_t        tbl [4];
    logic [71:0] w29 [4];
    bit          acc;
    logic [71:0] base_w;

    w29[0] = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    w29[1] = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
    w29[2] = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    w29[3] = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
    tbl[0] = '{8'd0,  0, 1'b0, w29[0], 4};
    tbl[1] = '{8'd16, 0, 1'b0, {8'd17, 8'd18, 8'd19, 8'd21, 8'd22, 8'd23, 8'd25, 8'd26, 8'd27}, 4};
    tbl[2] = '{8'd0,  5, 1'b0, w29[0], 4};
    tbl[3] = '{8'd0,  0, 1'b1, w29[0], 4};

    reset = 1'b0; pix_valid = 1'b0; pix_in = '0; win_ready = 1'b0;
    m_idx = 0; m_cnt = '0; fd_seen = 0;
    @(negedge clk);
    do_reset();

    for (int k = 0; k < 4; k++) begin
      got_q.delete();
      fd_seen = 0;
      run_frame(tbl[k].base, tbl[k].stall, tbl[k].toggle, tbl[k].exp_first);
      drain();
      chk($sformatf("n_windows_%0d", k), 72'(got_q.size()), 72'(tbl[k].exp_n));
      chk($sformatf("frame_done_cnt_%0d", k), 72'(fd_seen), 72'(1));
      if (got_q.size() == 4) begin
        chk($sformatf("first_win_%0d", k), got_q[0], tbl[k].exp_first);
        for (int j = 0; j < 4; j++) begin
          base_w = addw(w29[j], tbl[k].base);
          chk($sformatf("win_%0d_%0d", k, j), got_q[j], base_w);
        end
      end
      if (k == 1) begin
`ifdef WINDOW_GEN_COUNT_EN
        chk("win_count_two_frames", 72'(win_count), 72'(8));
`else
        chk("win_count_two_frames", 72'(win_count), 72'(0));
`endif
      end
    end

    // Reset after pixel 7, then a full restream.
    partial(7);
    do_reset();
    got_q.delete();
    run_frame(8'd0, 0, 1'b0, w29[0]);
    drain();
    chk("post_reset7_n", 72'(got_q.size()), 72'(4));
    if (got_q.size() == 4)
      for (int j = 0; j < 4; j++) chk($sformatf("post_reset7_win_%0d", j), got_q[j], w29[j]);

    // Reset while a window is pending (after pixel 11, held by win_ready=0).
    partial(11);
    cycle(1'b0, 8'd0, 1'b0, acc);
    chk("pending_valid", 72'(win_valid), 72'(1));
    do_reset();

    // Randomized traffic across many frames, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
